// File: rtl/board_pkg.sv
// Shared definitions for the board input front end: FSM encoding and sizing constants.
package board_pkg;

  localparam int DATA_W              = 8;
  localparam int DB_CYCLES_DEFAULT   = 20000;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

endpackage

// File: rtl/debounce_sync.sv
// One-bit synchronizer followed by a counter-based debouncer; db only follows raw
// after the synchronized level has differed from it for DB_CYCLES consecutive cycles.
module debounce_sync
  import board_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam logic [15:0] DbLast = 16'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw_s;
  logic                   db_q, db_d;
  logic [15:0]            cnt_q, cnt_d;

  assign raw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Any cycle where the synchronized level agrees with db restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (raw_s != db_q) begin
      if (cnt_q == DbLast) db_d  = raw_s;
      else                 cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/board_input.sv
// Board input front end: debounced step button captures the synchronized switch byte
// and offers it to the CPU through a valid/ack handshake with a one-cycle en_in strobe.
module board_input
  import board_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn,
  input  logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              en_in,
  output logic              overrun,
  output logic              busy
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;
  logic [DATA_W-1:0]                  sw_s;
  logic                               btn_db, btn_db_q, press;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              in_valid_q, in_valid_d;
  logic              en_in_q, en_in_d;
  logic              overrun_q, overrun_d;

  debounce_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_btn_db (
    .clk(clk),
    .rst(rst),
    .raw(btn),
    .db (btn_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_sync_q <= '0;
    else     sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw};
  end

  assign sw_s  = sw_sync_q[SYNC_STAGES-1];
  assign press = btn_db & ~btn_db_q;

  // A press while a sample is still pending only raises the sticky overrun flag.
  always_comb begin
    state_d    = state_q;
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    en_in_d    = 1'b0;
    overrun_d  = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          in_data_d  = sw_s;
          in_valid_d = 1'b1;
          en_in_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (press) overrun_d = 1'b1;
        if (in_ack) begin
          in_valid_d = 1'b0;
          state_d    = btn_db ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (!btn_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      en_in_q    <= 1'b0;
      overrun_q  <= 1'b0;
      btn_db_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      en_in_q    <= en_in_d;
      overrun_q  <= overrun_d;
      btn_db_q   <= btn_db;
    end
  end

  assign in_data  = in_data_q;
  assign in_valid = in_valid_q;
  assign en_in    = en_in_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_board_input.sv
// Self-checking bench for board_input: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of press capture and handshake.
module tb_board_input;

  localparam int DB   = 4;
  localparam int SYNC = 2;
  // Edges from a clean button rise to en_in: synchronizer, debounce run, capture.
  localparam int LAT  = SYNC + DB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn;
  logic       in_ack;
  logic [7:0] in_data;
  logic       in_valid, en_in, overrun, busy;
  wire [11:0] outVec = {in_data, in_valid, en_in, overrun, busy};

  int checkCount = 0;
  int passCount  = 0;

  bit         mBtnQ[$];
  logic [7:0] mSwQ[$];
  bit         mDb, mDbPrev, mPending, mWaitRel, mEn, mOverrun;
  int         mRun;
  logic [7:0] mData;

  board_input #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .in_ack(in_ack),
    .in_data(in_data), .in_valid(in_valid), .en_in(en_in),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mBtnQ = {};
    mSwQ  = {};
    for (int i = 0; i < SYNC; i++) begin
      mBtnQ.push_back(1'b0);
      mSwQ.push_back(8'h00);
    end
    mDb = 0; mDbPrev = 0; mRun = 0;
    mPending = 0; mWaitRel = 0; mEn = 0; mOverrun = 0; mData = 8'h00;
  endtask

  // Advances the model by one clock using the input levels seen at that edge.
  task automatic modelStep();
    bit press, oldDb;
    press = mDb && !mDbPrev;
    oldDb = mDb;
    mEn   = 0;
    if (mPending) begin
      if (press) mOverrun = 1;
      if (in_ack) begin
        mPending = 0;
        mWaitRel = mDb;
      end
    end else if (mWaitRel) begin
      if (!mDb) mWaitRel = 0;
    end else if (press) begin
      mData    = mSwQ[0];
      mPending = 1;
      mEn      = 1;
    end
    if (mBtnQ[0] != mDb) begin
      mRun++;
      if (mRun == DB) begin
        mDb  = mBtnQ[0];
        mRun = 0;
      end
    end else begin
      mRun = 0;
    end
    mDbPrev = oldDb;
    mBtnQ.push_back(btn);
    void'(mBtnQ.pop_front());
    mSwQ.push_back(sw);
    void'(mSwQ.pop_front());
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) modelStep();
      @(negedge clk);
    end
  endtask

  task automatic ackAndRelease();
    in_ack = 1'b1;
    applyStimulus(1);
    in_ack = 1'b0;
    btn    = 1'b0;
    applyStimulus(12);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; sw = 8'h00; in_ack = 1'b0;
    modelReset();
    applyStimulus(3);
    checkCount++;
    if (outVec !== 12'h000) $display("[TB] FAIL reset_outputs: got %h, expected 000", outVec);
    else passCount++;
    rst = 1'b0;
    applyStimulus(4);
    checkCount++;
    if ({in_valid, en_in, busy} !== 3'b000)
      $display("[TB] FAIL reset_release_idle: got %b, expected 000", {in_valid, en_in, busy});
    else passCount++;
  endtask

  task automatic test_clean_press();
    int enCount = 0, firstValid = -1, idleAt = -1;
    logic [7:0] dataAt = 8'h00;
    sw = 8'hA5; btn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(1);
      if (en_in) enCount++;
      if (in_valid && firstValid < 0) begin
        firstValid = c;
        dataAt     = in_data;
      end
    end
    checkCount++;
    if (enCount !== 1) $display("[TB] FAIL clean_en_count: got %0d, expected 1", enCount);
    else passCount++;
    checkCount++;
    if (firstValid !== LAT) $display("[TB] FAIL clean_latency: got %0d, expected %0d", firstValid, LAT);
    else passCount++;
    checkCount++;
    if (dataAt !== 8'hA5) $display("[TB] FAIL clean_data: got %h, expected a5", dataAt);
    else passCount++;
    in_ack = 1'b1;
    applyStimulus(1);
    in_ack = 1'b0;
    checkCount++;
    if ({in_valid, busy} !== 2'b01)
      $display("[TB] FAIL clean_ack_wait_rel: got %b, expected 01", {in_valid, busy});
    else passCount++;
    btn = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      applyStimulus(1);
      if (!busy && idleAt < 0) idleAt = c;
    end
    checkCount++;
    if (idleAt !== LAT) $display("[TB] FAIL clean_release_idle: got %0d, expected %0d", idleAt, LAT);
    else passCount++;
  endtask

  task automatic test_bounce();
    int bounceEn = 0, enCount = 0, firstEn = -1;
    sw = 8'h5C;
    for (int k = 0; k < 4; k++) begin
      btn = (k % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        applyStimulus(1);
        if (en_in) bounceEn++;
      end
    end
    btn = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      applyStimulus(1);
      if (en_in) begin
        enCount++;
        if (firstEn < 0) firstEn = c;
      end
    end
    checkCount++;
    if (bounceEn !== 0) $display("[TB] FAIL bounce_no_en: got %0d, expected 0", bounceEn);
    else passCount++;
    checkCount++;
    if (enCount !== 1 || firstEn !== LAT)
      $display("[TB] FAIL bounce_settled_en: got count %0d at %0d, expected 1 at %0d", enCount, firstEn, LAT);
    else passCount++;
    ackAndRelease();
  endtask

  task automatic test_overrun();
    sw = 8'h11; btn = 1'b1;
    applyStimulus(LAT);
    checkCount++;
    if (en_in !== 1'b1) $display("[TB] FAIL overrun_first_capture: got %b, expected 1", en_in);
    else passCount++;
    sw = 8'h22;
    applyStimulus(3);
    btn = 1'b0;
    applyStimulus(10);
    btn = 1'b1;
    applyStimulus(12);
    checkCount++;
    if ({overrun, in_valid, in_data} !== {2'b11, 8'h11})
      $display("[TB] FAIL overrun_set: got %b%b/%h, expected 11/11", overrun, in_valid, in_data);
    else passCount++;
    in_ack = 1'b1;
    applyStimulus(1);
    in_ack = 1'b0;
    checkCount++;
    if ({in_valid, overrun} !== 2'b01)
      $display("[TB] FAIL overrun_after_ack: got %b, expected 01", {in_valid, overrun});
    else passCount++;
    btn = 1'b0;
    applyStimulus(12);
    checkCount++;
    if ({overrun, busy} !== 2'b10)
      $display("[TB] FAIL overrun_sticky: got %b, expected 10", {overrun, busy});
    else passCount++;
  endtask

  task automatic test_freeze();
    sw = 8'h3C; btn = 1'b1;
    applyStimulus(LAT);
    sw = 8'hFF;
    applyStimulus(5);
    checkCount++;
    if (in_data !== 8'h3C) $display("[TB] FAIL freeze_data: got %h, expected 3c", in_data);
    else passCount++;
    ackAndRelease();
    btn = 1'b1;
    applyStimulus(LAT);
    checkCount++;
    if ({en_in, in_data} !== {1'b1, 8'hFF})
      $display("[TB] FAIL freeze_next_capture: got %b/%h, expected 1/ff", en_in, in_data);
    else passCount++;
    ackAndRelease();
  endtask

  task automatic test_back_to_back();
    in_ack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      int validCycles = 0, enCount = 0;
      logic [7:0] captured = 8'h00;
      sw  = 8'(k);
      btn = 1'b1;
      for (int c = 0; c < LAT + 4; c++) begin
        applyStimulus(1);
        if (in_valid) validCycles++;
        if (en_in) begin
          enCount++;
          captured = in_data;
        end
      end
      btn = 1'b0;
      for (int c = 0; c < 12; c++) begin
        applyStimulus(1);
        if (in_valid) validCycles++;
        if (en_in) enCount++;
      end
      checkCount++;
      if (validCycles !== 1 || enCount !== 1)
        $display("[TB] FAIL ack_held_press%0d_pulses: got valid %0d en %0d, expected 1 1", k, validCycles, enCount);
      else passCount++;
      checkCount++;
      if (captured !== 8'(k))
        $display("[TB] FAIL ack_held_press%0d_data: got %h, expected %h", k, captured, 8'(k));
      else passCount++;
    end
    in_ack = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    int earlyEn = 0;
    sw = 8'h5A; btn = 1'b1;
    applyStimulus(LAT);
    checkCount++;
    if (in_valid !== 1'b1) $display("[TB] FAIL midhold_valid: got %b, expected 1", in_valid);
    else passCount++;
    rst = 1'b1;
    modelReset();
    #1;
    checkCount++;
    if (outVec !== 12'h000) $display("[TB] FAIL midhold_async_clear: got %h, expected 000", outVec);
    else passCount++;
    @(negedge clk);
    applyStimulus(2);
    rst = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      applyStimulus(1);
      if (en_in) earlyEn++;
    end
    applyStimulus(1);
    checkCount++;
    if (earlyEn !== 0 || en_in !== 1'b1)
      $display("[TB] FAIL midhold_redebounce: got early %0d final %b, expected 0 1", earlyEn, en_in);
    else passCount++;
    ackAndRelease();
  endtask

  task automatic test_random();
    int cyc = 0;
    logic [11:0] expVec;
    rst = 1'b1;
    modelReset();
    btn = 1'b0; in_ack = 1'b0;
    applyStimulus(2);
    rst = 1'b0;
    while (cyc < 2500) begin
      int seg;
      btn = 1'($urandom_range(0, 1));
      seg = $urandom_range(1, 12);
      repeat (seg) begin
        sw     = 8'($urandom);
        in_ack = ($urandom_range(0, 3) == 0);
        applyStimulus(1);
        expVec = {mData, mPending, mEn, mOverrun, mPending || mWaitRel};
        checkCount++;
        if (outVec !== expVec)
          $display("[TB] FAIL random_cycle%0d: got %h, expected %h", cyc, outVec, expVec);
        else passCount++;
        cyc++;
      end
    end
    in_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_overrun();
    test_freeze();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/board_input.md
Name: board_input

Overview:
- Input-side board front end, the counterpart of the LED output path: brings the slide switches and a "step" push-button from the board pins into the divided CPU clock domain.
- Synchronizes and debounces the button, samples the switches on each clean press, and presents the byte to CPU_LS with a valid/ack handshake plus a one-cycle en_in strobe.
- Instantiated in the board top beside clk_div and CPU_LS. Clocked by the divided clk.

Parameters:
- DB_CYCLES, 20000, consecutive stable cycles required before the debounced button changes state; legal range 2..65535.
- SYNC_STAGES, 2, flip-flop synchronizer depth for btn and sw; minimum 2.

Ports:
- clk  input  1  system clock (divided board clock).
- rst  input  1  reset, asynchronous, active-high.
- sw  input  8  raw slide-switch levels, asynchronous.
- btn  input  1  raw step button, asynchronous, active-high, bouncy.
- in_ack  input  1  CPU accepts in_data; sampled only while in_valid=1.
- in_data  output  8  switch byte captured at the press.
- in_valid  output  1  in_data holds an unconsumed sample.
- en_in  output  1  one-cycle strobe on the capture cycle.
- overrun  output  1  sticky flag: a press edge arrived while a sample was pending.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): in_data=0, in_valid=0, en_in=0, overrun=0, busy=0, FSM=IDLE, debounce counter=0, debounced button=0, all synchronizer flops=0.
- Sync: btn and each sw bit pass through SYNC_STAGES flops. btn_s and sw_s are the final stages.
- Debounce: a 16-bit counter clears whenever btn_s equals btn_db, and increments while they differ. When the counter reaches DB_CYCLES-1 while still differing, btn_db takes btn_s on the next edge and the counter clears. Any bounce back clears the counter.
- Press edge: press = btn_db & ~btn_db_q, one cycle wide.
- FSM states IDLE, HOLD, WAIT_REL:
  - IDLE: on press, load in_data<=sw_s, set in_valid<=1 and en_in<=1 for that single cycle, then go to HOLD. Latency is one cycle from the press cycle to in_valid/en_in high.
  - HOLD: in_valid stays 1 and in_data is frozen. When in_ack=1, in_valid<=0, then go to WAIT_REL if btn_db=1, otherwise IDLE. A press in HOLD sets overrun<=1 and is otherwise discarded.
  - WAIT_REL: when btn_db=0, go to IDLE. A press here cannot occur because btn_db is already high.
- en_in is never high in two consecutive cycles.
- in_ack while in_valid=0 is ignored.
- in_ack held high continuously: each sample is consumed on the cycle after it appears.
- Switch changes after capture do not alter in_data.
- Simultaneous press and in_ack in HOLD: the ack is honoured, overrun is set, and no new capture occurs.
- Reset mid-HOLD: in_valid drops immediately, asynchronously, and the pending sample is lost.
- Counter width: 16 bits, no wrap, because it clears at DB_CYCLES-1.

Decomposition:
- Shared package board_pkg holds the FSM state encoding (IDLE=2'd0, HOLD=2'd1, WAIT_REL=2'd2), the default DB_CYCLES, and the data width constant 8.
- One sub-module, debounce_sync: a one-bit SYNC_STAGES synchronizer plus the debounce counter.
  - Ports: clk, rst, raw, db.
  - board_input instantiates it for btn. sw uses plain synchronizer flops only.

Test Plan (DB_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst=1 mid-simulation with btn=1 -> all outputs 0 at once. After release, no en_in until a full press is debounced.
- Clean press: sw=8'hA5, btn 0->1 held 20 cycles.
  - Required: exactly one en_in pulse, and in_valid=1 with in_data=8'hA5 one cycle after btn_db rises.
  - Then in_ack=1 for one cycle -> in_valid=0 next cycle. FSM in WAIT_REL until btn released, then IDLE.
- Bounce: btn toggles 1,0,1,0 every 2 cycles, then stable 1 -> no en_in during toggling, one en_in after 4 stable cycles plus synchronizer delay.
- Overrun: press, no ack, release, press again -> overrun=1, in_data keeps the first value. Then ack -> in_valid=0, and overrun stays 1 until reset.
- Data freeze: after capture of 8'h3C, change sw to 8'hFF before ack -> in_data stays 8'h3C. The next press captures 8'hFF.
- Continuous ack: in_ack tied 1, three separate presses with sw=1,2,3 -> three en_in pulses, each in_valid exactly one cycle wide, in_data 1, 2, 3 in order.
